// File: rtl/vram_oam_responder.sv
// Memory-side responder: VRAM and OAM arrays, PPU fetch port, CPU MMIO port and OAM DMA engine.
// Build option VRAM_LOCK_EN: when defined, the CPU is locked out of VRAM/OAM according to ppu_mode.
module vram_oam_responder #(
  parameter int DMA_LEN    = 160,
  parameter int LOCK_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_data,
  input  logic [1:0]  ppu_mode,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_rdata,
  output logic        dma_active
);

  localparam int          VRAM_SIZE    = 8192;
  localparam int          OAM_SIZE     = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  DMA_LAST     = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2
  } dma_state_e;

  function automatic logic is_vram(input logic [15:0] addr);
    return addr[15:13] == 3'b100;
  endfunction

  function automatic logic is_oam(input logic [15:0] addr);
    return (addr[15:8] == 8'hFE) && (addr[7:0] < 8'(OAM_SIZE));
  endfunction

  // Pages 0xE0-0xFF alias onto 0xC0-0xDF, as echo RAM does on the source bus.
  function automatic logic [7:0] clamp_src(input logic [7:0] s);
    if (s >= 8'hE0) begin
      return s & 8'hDF;
    end else begin
      return s;
    end
  endfunction

  logic [7:0] vram_q [VRAM_SIZE];
  logic [7:0] oam_q  [OAM_SIZE];

  dma_state_e  state_q, state_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  idx_q, idx_d;
  logic        dma_active_q, dma_active_d;
  logic        dma_rd_q, dma_rd_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  ppu_data_q, ppu_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  logic mode_oam_lock_s;
  logic vram_lock_s;
  logic oam_lock_s;
  logic dma_trig_s;
  logic oam_dma_we_s;
  logic oam_cpu_we_s;
  logic vram_we_s;
  logic cpu_vram_ok_s;
  logic cpu_oam_ok_s;

`ifdef VRAM_LOCK_EN
  // Delay line of mode-derived lock flags: bit 1 = OAM lock, bit 0 = VRAM lock.
  logic [1:0] lock_pipe_q [LOCK_DELAY];
  logic [1:0] lock_pipe_d [LOCK_DELAY];

  always_comb begin
    lock_pipe_d[0] = {ppu_mode[1], (ppu_mode == 2'd3)};
    for (int i = 1; i < LOCK_DELAY; i++) begin
      lock_pipe_d[i] = lock_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOCK_DELAY; i++) begin
        lock_pipe_q[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < LOCK_DELAY; i++) begin
        lock_pipe_q[i] <= lock_pipe_d[i];
      end
    end
  end

  assign mode_oam_lock_s = lock_pipe_q[LOCK_DELAY-1][1];
  assign vram_lock_s     = lock_pipe_q[LOCK_DELAY-1][0];
`else
  logic unused_mode_s;
  assign unused_mode_s   = ^ppu_mode;
  assign mode_oam_lock_s = 1'b0;
  assign vram_lock_s     = 1'b0;
`endif

  assign oam_lock_s = mode_oam_lock_s | dma_active_q;
  assign dma_trig_s = cpu_wr && (cpu_addr == DMA_REG_ADDR);

  // DMA sequencing; a trigger write always restarts the engine from index 0.
  always_comb begin
    state_d      = state_q;
    src_hi_d     = src_hi_q;
    idx_d        = idx_q;
    dma_active_d = dma_active_q;
    dma_rd_d     = 1'b0;
    dma_addr_d   = dma_addr_q;
    oam_dma_we_s = 1'b0;
    if (dma_trig_s) begin
      src_hi_d     = clamp_src(cpu_wdata);
      idx_d        = 8'd0;
      state_d      = DMA_READ;
      dma_active_d = 1'b1;
      dma_rd_d     = 1'b1;
      dma_addr_d   = {src_hi_d, 8'h00};
    end else begin
      case (state_q)
        DMA_IDLE: begin
          state_d = DMA_IDLE;
        end
        DMA_READ: begin
          state_d = DMA_WRITE;
        end
        DMA_WRITE: begin
          oam_dma_we_s = 1'b1;
          idx_d        = idx_q + 8'd1;
          if (idx_q == DMA_LAST) begin
            state_d      = DMA_IDLE;
            dma_active_d = 1'b0;
          end else begin
            state_d    = DMA_READ;
            dma_rd_d   = 1'b1;
            dma_addr_d = {src_hi_q, 8'h00} + {8'h00, idx_d};
          end
        end
        default: begin
          state_d      = DMA_IDLE;
          dma_active_d = 1'b0;
        end
      endcase
    end
  end

  // CPU and PPU access decode; array reads happen before this edge's writes land.
  always_comb begin
    cpu_vram_ok_s = is_vram(cpu_addr) && !vram_lock_s;
    cpu_oam_ok_s  = is_oam(cpu_addr) && !oam_lock_s;
    vram_we_s     = cpu_wr && cpu_vram_ok_s;
    oam_cpu_we_s  = cpu_wr && cpu_oam_ok_s && !oam_dma_we_s;

    if (!cpu_rd) begin
      cpu_rdata_d = cpu_rdata_q;
    end else if (cpu_vram_ok_s) begin
      cpu_rdata_d = vram_q[cpu_addr[12:0]];
    end else if (cpu_oam_ok_s) begin
      cpu_rdata_d = oam_q[cpu_addr[7:0]];
    end else if (cpu_addr == DMA_REG_ADDR) begin
      cpu_rdata_d = src_hi_q;
    end else begin
      cpu_rdata_d = 8'hFF;
    end

    if (!ppu_rd) begin
      ppu_data_d = ppu_data_q;
    end else if (is_vram(ppu_addr)) begin
      ppu_data_d = vram_q[ppu_addr[12:0]];
    end else if (is_oam(ppu_addr)) begin
      ppu_data_d = oam_q[ppu_addr[7:0]];
    end else begin
      ppu_data_d = 8'hFF;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DMA_IDLE;
      src_hi_q     <= 8'h00;
      idx_q        <= 8'd0;
      dma_active_q <= 1'b0;
      dma_rd_q     <= 1'b0;
      dma_addr_q   <= 16'h0000;
      ppu_data_q   <= 8'hFF;
      cpu_rdata_q  <= 8'hFF;
    end else begin
      state_q      <= state_d;
      src_hi_q     <= src_hi_d;
      idx_q        <= idx_d;
      dma_active_q <= dma_active_d;
      dma_rd_q     <= dma_rd_d;
      dma_addr_q   <= dma_addr_d;
      ppu_data_q   <= ppu_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // VRAM write port (CPU only); contents are not reset.
  always_ff @(posedge clk) begin
    if (vram_we_s) begin
      vram_q[cpu_addr[12:0]] <= cpu_wdata;
    end
  end

  // OAM write port; the DMA engine wins over the CPU.
  always_ff @(posedge clk) begin
    if (oam_dma_we_s) begin
      oam_q[idx_q] <= dma_rdata;
    end else if (oam_cpu_we_s) begin
      oam_q[cpu_addr[7:0]] <= cpu_wdata;
    end
  end

  assign ppu_data   = ppu_data_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rd     = dma_rd_q;
  assign dma_addr   = dma_addr_q;
  assign dma_active = dma_active_q;

endmodule
